sram_port_arbiter: RTL

//  Shares the single-port 16K x 32 SRAM macro between a read-burst requester and a write-burst requester.

---
 rtl/sram_arb_pkg.sv | 21 ++
 rtl/sram_rr_arb2.sv | 28 ++
 rtl/sram_port_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and default widths for the single-port SRAM read/write arbiter.
package sram_arb_pkg;

    localparam int SRAM_ADDR_W = 14;
    localparam int SRAM_DATA_W = 32;
    localparam int SRAM_LEN_W  = 4;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_DATA,
        WR_BEAT,
        WR_DONE
    } arb_state_e;

    typedef enum logic {
        OWN_RD,
        OWN_WR
    } owner_e;

endpackage

// File: rtl/sram_rr_arb2.sv
// Two-way round-robin pick between the read and write burst requesters.
module sram_rr_arb2
    import sram_arb_pkg::*;
(
    input  logic   req_rd_i,
    input  logic   req_wr_i,
    input  owner_e last_owner_i,
    output logic   gnt_rd_o,
    output logic   gnt_wr_o
);

    always_comb begin
        gnt_rd_o = 1'b0;
        gnt_wr_o = 1'b0;
        if (req_rd_i && req_wr_i) begin
            // on a tie the side that did not own the SRAM last time wins
            if (last_owner_i == OWN_RD) begin
                gnt_wr_o = 1'b1;
            end else begin
                gnt_rd_o = 1'b1;
            end
        end else begin
            gnt_rd_o = req_rd_i;
            gnt_wr_o = req_wr_i;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Burst-granular round-robin owner of the single-port SRAM macro; sequences INCR read/write beats.
//  state    | meaning
//  IDLE     | no owner, sampling requests
//  RD_ISSUE | read address presented to macro
//  RD_DATA  | read beat valid, waiting for rd_ready_i
//  WR_BEAT  | write beats accepted, one per valid cycle
//  WR_DONE  | single-cycle done pulse after last write beat
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W   = SRAM_ADDR_W,
    parameter int DATA_W   = SRAM_DATA_W,
    parameter int LEN_W    = SRAM_LEN_W,
    parameter int STRB_W   = DATA_W / 8,
    parameter bit RD_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              rd_req_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [LEN_W-1:0]  rd_len_i,
    output logic              rd_gnt_o,
    output logic              rd_valid_o,
    input  logic              rd_ready_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_last_o,

    input  logic              wr_req_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [LEN_W-1:0]  wr_len_i,
    output logic              wr_gnt_o,
    input  logic              wr_valid_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [STRB_W-1:0] wr_strb_i,
    output logic              wr_ready_o,
    output logic              wr_done_o,

    output logic [ADDR_W-1:0] sram_a_o,
    output logic [DATA_W-1:0] sram_di_o,
    input  logic [DATA_W-1:0] sram_do_i,
    output logic              sram_cs_o,
    output logic              sram_oe_o,
    output logic [STRB_W-1:0] sram_web_o
);

    arb_state_e        state_q;
    owner_e            last_owner_q;
    logic [ADDR_W-1:0] cur_addr_q;
    logic [LEN_W-1:0]  beat_cnt_q;
    logic              rd_gnt_q;
    logic              wr_gnt_q;
    logic              wr_done_q;

    logic              pick_rd;
    logic              pick_wr;
    logic              last_beat;

    sram_rr_arb2 u_rr (
        .req_rd_i     (rd_req_i),
        .req_wr_i     (wr_req_i),
        .last_owner_i (last_owner_q),
        .gnt_rd_o     (pick_rd),
        .gnt_wr_o     (pick_wr)
    );

    assign last_beat = (beat_cnt_q == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_owner_q <= RD_FIRST ? OWN_WR : OWN_RD;
            cur_addr_q   <= '0;
            beat_cnt_q   <= '0;
            rd_gnt_q     <= 1'b0;
            wr_gnt_q     <= 1'b0;
            wr_done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_rd) begin
                        state_q      <= RD_ISSUE;
                        rd_gnt_q     <= 1'b1;
                        cur_addr_q   <= rd_addr_i;
                        beat_cnt_q   <= rd_len_i;
                        last_owner_q <= OWN_RD;
                    end else if (pick_wr) begin
                        state_q      <= WR_BEAT;
                        wr_gnt_q     <= 1'b1;
                        cur_addr_q   <= wr_addr_i;
                        beat_cnt_q   <= wr_len_i;
                        last_owner_q <= OWN_WR;
                    end
                end
                RD_ISSUE: begin
                    state_q <= RD_DATA;
                end
                RD_DATA: begin
                    if (rd_ready_i) begin
                        if (last_beat) begin
                            state_q  <= IDLE;
                            rd_gnt_q <= 1'b0;
                        end else begin
                            state_q    <= RD_ISSUE;
                            cur_addr_q <= cur_addr_q + ADDR_W'(1);
                            beat_cnt_q <= beat_cnt_q - LEN_W'(1);
                        end
                    end
                end
                WR_BEAT: begin
                    if (wr_valid_i) begin
                        if (last_beat) begin
                            state_q   <= WR_DONE;
                            wr_gnt_q  <= 1'b0;
                            wr_done_q <= 1'b1;
                        end else begin
                            cur_addr_q <= cur_addr_q + ADDR_W'(1);
                            beat_cnt_q <= beat_cnt_q - LEN_W'(1);
                        end
                    end
                end
                WR_DONE: begin
                    state_q   <= IDLE;
                    wr_done_q <= 1'b0;
                end
                default: begin
                    state_q   <= IDLE;
                    rd_gnt_q  <= 1'b0;
                    wr_gnt_q  <= 1'b0;
                    wr_done_q <= 1'b0;
                end
            endcase
        end
    end

    assign rd_gnt_o  = rd_gnt_q;
    assign wr_gnt_o  = wr_gnt_q;
    assign wr_done_o = wr_done_q;
    // address is held through RD_DATA, so the macro output stays stable under backpressure
    assign rd_data_o = sram_do_i;

    always_comb begin
        sram_a_o   = '0;
        sram_di_o  = '0;
        sram_cs_o  = 1'b0;
        sram_oe_o  = 1'b0;
        sram_web_o = '1;
        rd_valid_o = 1'b0;
        rd_last_o  = 1'b0;
        wr_ready_o = 1'b0;
        case (state_q)
            RD_ISSUE: begin
                sram_cs_o = 1'b1;
                sram_oe_o = 1'b1;
                sram_a_o  = cur_addr_q;
            end
            RD_DATA: begin
                sram_cs_o  = 1'b1;
                sram_oe_o  = 1'b1;
                sram_a_o   = cur_addr_q;
                rd_valid_o = 1'b1;
                rd_last_o  = last_beat;
            end
            WR_BEAT: begin
                wr_ready_o = 1'b1;
                sram_cs_o  = wr_valid_i;
                sram_web_o = wr_valid_i ? ~wr_strb_i : '1;
                sram_a_o   = cur_addr_q;
                sram_di_o  = wr_data_i;
            end
            default: begin
            end
        endcase
    end

endmodule
